// File: rtl/mf8_reg_dbg_arb.sv
// mf8_reg_dbg_arb
//   Shares the mf8 register file between the core pipeline and a debug/host
//   port. Core register traffic normally passes straight through to mf8_reg.
//   A debug request stalls the core for three cycles. During those cycles the
//   arbiter performs one 8-bit register read or write. It then restores the
//   core's Rd operand view before releasing the stall.
//
// Ports
//   Clk, Reset_n                  clock, asynchronous active-low reset
//   Core_Wr/Rd_Addr/Rr_Addr/Data  core register-file traffic
//   Core_Lock                     core multi-cycle sequence, blocks debug grant
//   Stall                         core freeze request
//   Dbg_Req/We/Addr/WData         debug access request and payload
//   Dbg_Ack, Dbg_RData            completion pulse and read data
//   Rf_Wr/Rd_Addr/Rr_Addr/Data_In drive mf8_reg
//   Rf_Rd_Data                    mf8_reg Rd read data (1-cycle sync read)
//
// Parameters
//   MIN_GAP  idle cycles enforced between debug accesses (0..15)

module mf8_reg_dbg_arb #(
  parameter int unsigned MIN_GAP = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Core_Wr,
  input  logic [4:0] Core_Rd_Addr,
  input  logic [4:0] Core_Rr_Addr,
  input  logic [7:0] Core_Data,
  input  logic       Core_Lock,
  output logic       Stall,
  input  logic       Dbg_Req,
  input  logic       Dbg_We,
  input  logic [4:0] Dbg_Addr,
  input  logic [7:0] Dbg_WData,
  output logic       Dbg_Ack,
  output logic [7:0] Dbg_RData,
  output logic       Rf_Wr,
  output logic [4:0] Rf_Rd_Addr,
  output logic [4:0] Rf_Rr_Addr,
  output logic [7:0] Rf_Data_In,
  input  logic [7:0] Rf_Rd_Data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_REST = 2'd3
  } state_t;

  localparam logic [3:0] GapLoad = 4'(MIN_GAP);

  state_t     state_q;
  logic [3:0] gap_q;
  logic       stall_q;
  logic       ack_q;
  logic [7:0] rdata_q;
  logic       we_q;
  logic [4:0] addr_q;
  logic [7:0] wdata_q;

  logic       grant;
  logic       rfWr_d;
  logic [4:0] rfRdAddr_d;
  logic [7:0] rfData_d;

  // A debug access may only start from IDLE. The core must not be inside a
  // locked sequence. The gap since the previous access must have elapsed.
  assign grant = (state_q == IDLE) && Dbg_Req && !Core_Lock && (gap_q == 4'd0);

  // Access sequencer. Stall and Dbg_Ack are registered here so they depend
  // only on state, never combinationally on Dbg_Req.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      gap_q   <= 4'd0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 8'h00;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gap_q != 4'd0) begin
            gap_q <= gap_q - 4'd1;
          end
          if (grant) begin
            state_q <= S_ADDR;
            stall_q <= 1'b1;
            we_q    <= Dbg_We;
            addr_q  <= Dbg_Addr;
            wdata_q <= Dbg_WData;
          end
        end
        S_ADDR: begin
          state_q <= S_DATA;
        end
        S_DATA: begin
          // The read was addressed in S_ADDR. The register file bypass
          // folds in a same-address drain write from that cycle.
          if (!we_q) begin
            rdata_q <= Rf_Rd_Data;
          end
          ack_q   <= 1'b1;
          state_q <= S_REST;
        end
        S_REST: begin
          stall_q <= 1'b0;
          gap_q   <= GapLoad;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Register-file steering.
  // S_ADDR drains the core write that pairs with the last IDLE address and
  // points Rd at the debug register. S_DATA issues the debug write and
  // re-reads the core's Rd address. This makes the core's operand valid
  // again in S_REST.
  always_comb begin
    rfWr_d     = Core_Wr;
    rfRdAddr_d = Core_Rd_Addr;
    rfData_d   = Core_Data;
    case (state_q)
      S_ADDR: begin
        rfRdAddr_d = addr_q;
      end
      S_DATA: begin
        rfWr_d   = we_q;
        rfData_d = wdata_q;
      end
      S_REST: begin
        rfWr_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // No register-file write may slip through while reset is held.
  assign Rf_Wr      = rfWr_d & Reset_n;
  assign Rf_Rd_Addr = rfRdAddr_d;
  assign Rf_Rr_Addr = Core_Rr_Addr;
  assign Rf_Data_In = rfData_d;

  assign Stall     = stall_q;
  assign Dbg_Ack   = ack_q;
  assign Dbg_RData = rdata_q;

endmodule

// File: tb/tb_mf8_reg_dbg_arb.sv
// tb_mf8_reg_dbg_arb
//   Self-checking bench for mf8_reg_dbg_arb. It includes a small mf8_reg model
//   with the following behaviour:
//   - synchronous Rd read;
//   - write address is the Rd address of the previous cycle;
//   - write-to-read bypass.
//   Expected debug read data is queued when a request is driven. It is popped
//   and compared when Dbg_Ack appears.

module tb_mf8_reg_dbg_arb;

  localparam int MIN_GAP = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Core_Wr;
  logic [4:0] Core_Rd_Addr;
  logic [4:0] Core_Rr_Addr;
  logic [7:0] Core_Data;
  logic       Core_Lock;
  logic       Stall;
  logic       Dbg_Req;
  logic       Dbg_We;
  logic [4:0] Dbg_Addr;
  logic [7:0] Dbg_WData;
  logic       Dbg_Ack;
  logic [7:0] Dbg_RData;
  logic       Rf_Wr;
  logic [4:0] Rf_Rd_Addr;
  logic [4:0] Rf_Rr_Addr;
  logic [7:0] Rf_Data_In;
  logic [7:0] Rf_Rd_Data;

  int nChecks = 0;
  int nFails  = 0;
  int cycleNo = 0;
  int wrCount = 0;

  logic [7:0] expQ[$];

  logic [7:0] rf [32] = '{default: 8'h00};
  logic [4:0] wa = 5'd0;

  mf8_reg_dbg_arb #(.MIN_GAP(MIN_GAP)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Core_Wr(Core_Wr), .Core_Rd_Addr(Core_Rd_Addr), .Core_Rr_Addr(Core_Rr_Addr),
    .Core_Data(Core_Data), .Core_Lock(Core_Lock), .Stall(Stall),
    .Dbg_Req(Dbg_Req), .Dbg_We(Dbg_We), .Dbg_Addr(Dbg_Addr), .Dbg_WData(Dbg_WData),
    .Dbg_Ack(Dbg_Ack), .Dbg_RData(Dbg_RData),
    .Rf_Wr(Rf_Wr), .Rf_Rd_Addr(Rf_Rd_Addr), .Rf_Rr_Addr(Rf_Rr_Addr),
    .Rf_Data_In(Rf_Data_In), .Rf_Rd_Data(Rf_Rd_Data)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleNo <= cycleNo + 1;

  // Register file model standing in for mf8_reg.
  always @(posedge Clk) begin
    wa <= Rf_Rd_Addr;
    if (Rf_Wr) begin
      rf[wa]  <= Rf_Data_In;
      wrCount <= wrCount + 1;
    end
    Rf_Rd_Data <= (Rf_Wr && wa == Rf_Rd_Addr) ? Rf_Data_In : rf[Rf_Rd_Addr];
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic stepIdle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Core write: present the address, then pulse Wr with data the next cycle.
  task automatic coreWrite(input logic [4:0] addr, input logic [7:0] data);
    Core_Rd_Addr = addr;
    Core_Wr      = 1'b0;
    @(posedge Clk); #1;
    Core_Wr   = 1'b1;
    Core_Data = data;
    @(posedge Clk); #1;
    Core_Wr = 1'b0;
  endtask

  // Drive one debug access and record what the DUT did. Req is released on
  // the edge after Ack is seen.
  task automatic applyStimulus(input logic we, input logic [4:0] addr,
                               input logic [7:0] wdata,
                               output int stallCnt, output int ackAt,
                               output int ackCycle, output logic [7:0] rdAtAck,
                               output logic [7:0] rfAtAck,
                               output logic stallAfter);
    bit done;
    done = 0; stallCnt = 0; ackAt = -1; ackCycle = -1;
    rdAtAck = 8'h00; rfAtAck = 8'h00; stallAfter = 1'b1;
    Dbg_Req = 1'b1; Dbg_We = we; Dbg_Addr = addr; Dbg_WData = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Clk);
      if (Stall) stallCnt++;
      if (Dbg_Ack) begin
        ackAt = c; ackCycle = cycleNo; rdAtAck = Dbg_RData;
        rfAtAck = Rf_Rd_Data; done = 1;
      end
      @(posedge Clk); #1;
    end
    Dbg_Req = 1'b0;
    @(negedge Clk);
    stallAfter = Stall;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; Core_Wr = 1'b1; Core_Rd_Addr = 5'd3; Core_Rr_Addr = 5'd17;
    Core_Data = 8'hEE; Core_Lock = 1'b0;
    Dbg_Req = 1'b0; Dbg_We = 1'b0; Dbg_Addr = 5'd0; Dbg_WData = 8'h00;
    #2;
    nChecks++; if (Stall !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall: got %b want 0", Stall); end
    nChecks++; if (Dbg_Ack !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack: got %b want 0", Dbg_Ack); end
    nChecks++; if (Dbg_RData !== 8'h00) begin nFails++; $display("[TB] FAIL reset_rdata: got %h want 00", Dbg_RData); end
    nChecks++; if (Rf_Wr !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rfwr: got %b want 0", Rf_Wr); end
    nChecks++; if (Rf_Rr_Addr !== 5'd17) begin nFails++; $display("[TB] FAIL reset_rr: got %0d want 17", Rf_Rr_Addr); end
    nChecks++; if (Rf_Rd_Addr !== 5'd3) begin nFails++; $display("[TB] FAIL reset_rd: got %0d want 3", Rf_Rd_Addr); end
    Core_Wr = 1'b0;
    stepIdle(2);
    Reset_n = 1'b1;
    stepIdle(1);
  endtask

  task automatic test_debug_read;
    int sc, aa, ac; logic [7:0] rd, rfa; logic sa; logic [7:0] e;
    coreWrite(5'd5, 8'hA7);
    coreWrite(5'd7, 8'h42);
    Core_Rd_Addr = 5'd7; Core_Rr_Addr = 5'd5;
    stepIdle(1);
    expQ.push_back(8'hA7);
    applyStimulus(1'b0, 5'd5, 8'h00, sc, aa, ac, rd, rfa, sa);
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (sc !== 3) begin nFails++; $display("[TB] FAIL read_stall_cycles: got %0d want 3", sc); end
    nChecks++; if (aa !== 3) begin nFails++; $display("[TB] FAIL read_ack_latency: got %0d want 3", aa); end
    nChecks++; if (sa !== 1'b0) begin nFails++; $display("[TB] FAIL read_stall_release: got %b want 0", sa); end
    nChecks++; if (rd !== e) begin nFails++; $display("[TB] FAIL read_rdata: got %h want %h", rd, e); end
    nChecks++; if (rfa !== 8'h42) begin nFails++; $display("[TB] FAIL read_core_restore: got %h want 42", rfa); end
    nChecks++; if (Rf_Rr_Addr !== 5'd5) begin nFails++; $display("[TB] FAIL rr_passthrough: got %0d want 5", Rf_Rr_Addr); end
  endtask

  task automatic test_debug_write;
    int sc, aa, ac; logic [7:0] rd, rfa; logic sa;
    stepIdle(8);
    Core_Rd_Addr = 5'd31;
    applyStimulus(1'b1, 5'd31, 8'h3C, sc, aa, ac, rd, rfa, sa);
    nChecks++; if (aa !== 3) begin nFails++; $display("[TB] FAIL write_ack_latency: got %0d want 3", aa); end
    nChecks++; if (sc !== 3) begin nFails++; $display("[TB] FAIL write_stall_cycles: got %0d want 3", sc); end
    nChecks++; if (rd !== 8'hA7) begin nFails++; $display("[TB] FAIL write_rdata_held: got %h want a7", rd); end
    nChecks++; if (rfa !== 8'h3C) begin nFails++; $display("[TB] FAIL write_core_view: got %h want 3c", rfa); end
    nChecks++; if (rf[31] !== 8'h3C) begin nFails++; $display("[TB] FAIL write_z_high: got %h want 3c", rf[31]); end
    nChecks++; if (Rf_Rd_Data !== 8'h3C) begin nFails++; $display("[TB] FAIL write_core_read: got %h want 3c", Rf_Rd_Data); end
  endtask

  task automatic test_drain_collision;
    int w0; logic [7:0] e;
    stepIdle(8);
    Core_Rd_Addr = 5'd5; Core_Wr = 1'b0;
    Dbg_Req = 1'b1; Dbg_We = 1'b0; Dbg_Addr = 5'd5; Dbg_WData = 8'h00;
    expQ.push_back(8'h11);
    w0 = wrCount;
    @(posedge Clk); #1;
    Core_Wr = 1'b1; Core_Data = 8'h11; Core_Rd_Addr = 5'd9;
    @(negedge Clk);
    nChecks++; if (Stall !== 1'b1) begin nFails++; $display("[TB] FAIL drain_stall: got %b want 1", Stall); end
    @(posedge Clk); #1;
    Core_Data = 8'h99;
    @(posedge Clk); #1;
    @(negedge Clk);
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (Dbg_Ack !== 1'b1) begin nFails++; $display("[TB] FAIL drain_ack: got %b want 1", Dbg_Ack); end
    nChecks++; if (Dbg_RData !== e) begin nFails++; $display("[TB] FAIL drain_rdata: got %h want %h", Dbg_RData, e); end
    nChecks++; if (Rf_Wr !== 1'b0) begin nFails++; $display("[TB] FAIL rest_no_write: got %b want 0", Rf_Wr); end
    @(posedge Clk); #1;
    Dbg_Req = 1'b0; Core_Wr = 1'b0;
    stepIdle(1);
    nChecks++; if (wrCount - w0 !== 1) begin nFails++; $display("[TB] FAIL drain_write_count: got %0d want 1", wrCount - w0); end
    nChecks++; if (rf[5] !== 8'h11) begin nFails++; $display("[TB] FAIL drain_commit: got %h want 11", rf[5]); end
  endtask

  task automatic test_lock_and_gap;
    int lockStalls, sc, aa, ac1, ac2; logic [7:0] rd, rfa, e; logic sa;
    stepIdle(8);
    Core_Rd_Addr = 5'd7;
    Core_Lock = 1'b1;
    Dbg_Req = 1'b1; Dbg_We = 1'b0; Dbg_Addr = 5'd7;
    lockStalls = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Stall || Dbg_Ack) lockStalls++;
      @(posedge Clk); #1;
    end
    nChecks++; if (lockStalls !== 0) begin nFails++; $display("[TB] FAIL lock_blocks: got %0d want 0", lockStalls); end
    Core_Lock = 1'b0;
    expQ.push_back(8'h42);
    applyStimulus(1'b0, 5'd7, 8'h00, sc, aa, ac1, rd, rfa, sa);
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (aa !== 3) begin nFails++; $display("[TB] FAIL unlock_ack_latency: got %0d want 3", aa); end
    nChecks++; if (rd !== e) begin nFails++; $display("[TB] FAIL unlock_rdata: got %h want %h", rd, e); end
    expQ.push_back(8'h11);
    applyStimulus(1'b0, 5'd5, 8'h00, sc, aa, ac2, rd, rfa, sa);
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (ac2 - ac1 !== 4 + MIN_GAP) begin nFails++; $display("[TB] FAIL ack_spacing: got %0d want %0d", ac2 - ac1, 4 + MIN_GAP); end
    nChecks++; if (rd !== e) begin nFails++; $display("[TB] FAIL b2b_rdata: got %h want %h", rd, e); end
    nChecks++; if (sc !== 3) begin nFails++; $display("[TB] FAIL b2b_stall_cycles: got %0d want 3", sc); end
  endtask

  task automatic test_reset_mid_access;
    int sc, aa, ac; logic [7:0] rd, rfa, e; logic sa;
    stepIdle(8);
    coreWrite(5'd2, 8'h00);
    Core_Rd_Addr = 5'd2;
    Dbg_Req = 1'b1; Dbg_We = 1'b1; Dbg_Addr = 5'd2; Dbg_WData = 8'h55;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    nChecks++; if (Stall !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_stall: got %b want 0", Stall); end
    nChecks++; if (Dbg_Ack !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_ack: got %b want 0", Dbg_Ack); end
    nChecks++; if (Rf_Wr !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_rfwr: got %b want 0", Rf_Wr); end
    Dbg_Req = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    stepIdle(1);
    nChecks++; if (rf[2] !== 8'h00) begin nFails++; $display("[TB] FAIL midreset_write_lost: got %h want 00", rf[2]); end
    expQ.push_back(8'h00);
    applyStimulus(1'b0, 5'd2, 8'h00, sc, aa, ac, rd, rfa, sa);
    e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    nChecks++; if (aa !== 3) begin nFails++; $display("[TB] FAIL post_reset_no_gap: got %0d want 3", aa); end
    nChecks++; if (rd !== e) begin nFails++; $display("[TB] FAIL post_reset_rdata: got %h want %h", rd, e); end
  endtask

  initial begin
    test_reset;
    test_debug_read;
    test_debug_write;
    test_drain_collision;
    test_lock_and_gap;
    test_reset_mid_access;
    nChecks++;
    if (expQ.size() !== 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drain: got %0d left want 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
